// File: rtl/usb_rx_nrzi_decoder.sv
// USB full-speed receive front end: NRZI decode, SYNC/EOP detection and bit unstuffing.
// Optional bus-reset detector enabled by defining USB_RX_BUS_RESET_DET_EN.
`default_nettype none

module usb_rx_nrzi_decoder #(
    parameter int RESET_SE0_BITS = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_dp,
    input  logic rx_dm,
    input  logic bit_stb,
    output logic data_out,
    output logic data_valid,
    output logic pkt_active,
    output logic sync_det,
    output logic eop_det,
    output logic rx_error
`ifdef USB_RX_BUS_RESET_DET_EN
    ,
    output logic bus_reset
`endif
);

    localparam int CW = $clog2(RESET_SE0_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_DATA = 2'd2,
        S_EOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          prev_j_q, prev_j_d;
    logic [6:0]    sync_sr_q, sync_sr_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    ones_q, ones_d;
    logic [CW-1:0] se0_cnt_q, se0_cnt_d;
    logic          data_out_q, data_out_d;
    logic          dv_q, dv_d;
    logic          pkt_q, pkt_d;
    logic          sync_q, sync_d;
    logic          eop_q, eop_d;
    logic          err_q, err_d;

    logic w_j, w_k, w_se0, w_se1, w_bit;

    assign w_j   =  rx_dp & ~rx_dm;
    assign w_k   = ~rx_dp &  rx_dm;
    assign w_se0 = ~rx_dp & ~rx_dm;
    assign w_se1 =  rx_dp &  rx_dm;
    // On a J/K sample, dp alone identifies the state; equal to previous means a 1.
    assign w_bit = (rx_dp == prev_j_q);

    always_comb begin
        state_d    = state_q;
        prev_j_d   = prev_j_q;
        sync_sr_d  = sync_sr_q;
        bit_cnt_d  = bit_cnt_q;
        ones_d     = ones_q;
        se0_cnt_d  = se0_cnt_q;
        data_out_d = data_out_q;
        pkt_d      = pkt_q;
        dv_d       = 1'b0;
        sync_d     = 1'b0;
        eop_d      = 1'b0;
        err_d      = 1'b0;

        if (bit_stb) begin
            if (w_j || w_k) begin
                prev_j_d = rx_dp;
            end
            case (state_q)
                S_IDLE: begin
                    if (w_k) begin
                        state_d   = S_SYNC;
                        sync_sr_d = '0;
                        bit_cnt_d = 3'd1;
                    end
                end
                S_SYNC: begin
                    if (w_se0) begin
                        state_d   = S_EOP;
                        se0_cnt_d = CW'(1);
                    end else if (w_se1) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        pkt_d   = 1'b0;
                    end else if (bit_cnt_q == 3'd7) begin
                        if (sync_sr_q == '0 && w_bit) begin
                            state_d = S_DATA;
                            sync_d  = 1'b1;
                            pkt_d   = 1'b1;
                            ones_d  = 3'd1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        sync_sr_d = {sync_sr_q[5:0], w_bit};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                S_DATA: begin
                    if (w_se0) begin
                        state_d   = S_EOP;
                        se0_cnt_d = CW'(1);
                    end else if (w_se1) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        pkt_d   = 1'b0;
                    end else if (ones_q == 3'd6) begin
                        // Six ones in a row: this bit must be the stuffed 0.
                        ones_d = 3'd0;
                        if (w_bit) begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                            pkt_d   = 1'b0;
                        end
                    end else begin
                        dv_d       = 1'b1;
                        data_out_d = w_bit;
                        ones_d     = w_bit ? ones_q + 3'd1 : 3'd0;
                    end
                end
                S_EOP: begin
                    if (w_se0) begin
                        if (se0_cnt_q != CW'(RESET_SE0_BITS)) begin
                            se0_cnt_d = se0_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = S_IDLE;
                        pkt_d   = 1'b0;
                        if (w_j && se0_cnt_q >= CW'(1) && se0_cnt_q <= CW'(3)) begin
                            eop_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            prev_j_q   <= 1'b1;
            sync_sr_q  <= '0;
            bit_cnt_q  <= '0;
            ones_q     <= '0;
            se0_cnt_q  <= '0;
            data_out_q <= 1'b0;
            dv_q       <= 1'b0;
            pkt_q      <= 1'b0;
            sync_q     <= 1'b0;
            eop_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_j_q   <= prev_j_d;
            sync_sr_q  <= sync_sr_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_q     <= ones_d;
            se0_cnt_q  <= se0_cnt_d;
            data_out_q <= data_out_d;
            dv_q       <= dv_d;
            pkt_q      <= pkt_d;
            sync_q     <= sync_d;
            eop_q      <= eop_d;
            err_q      <= err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = dv_q;
    assign pkt_active = pkt_q;
    assign sync_det   = sync_q;
    assign eop_det    = eop_q;
    assign rx_error   = err_q;

`ifdef USB_RX_BUS_RESET_DET_EN
    // Counts consecutive SE0 samples regardless of packet state.
    logic [CW-1:0] br_cnt_q, br_cnt_d;
    logic          bus_reset_q, bus_reset_d;

    always_comb begin
        br_cnt_d    = br_cnt_q;
        bus_reset_d = bus_reset_q;
        if (bit_stb) begin
            if (w_se0) begin
                if (br_cnt_q != CW'(RESET_SE0_BITS)) begin
                    br_cnt_d = br_cnt_q + 1'b1;
                end
                bus_reset_d = (br_cnt_d == CW'(RESET_SE0_BITS));
            end else begin
                br_cnt_d    = '0;
                bus_reset_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q    <= '0;
            bus_reset_q <= 1'b0;
        end else begin
            br_cnt_q    <= br_cnt_d;
            bus_reset_q <= bus_reset_d;
        end
    end

    assign bus_reset = bus_reset_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_usb_rx_nrzi_decoder.sv
// Directed, table-driven bench for usb_rx_nrzi_decoder.
`default_nettype none

module tb_usb_rx_nrzi_decoder;

    localparam logic [1:0] LJ = 2'b10;
    localparam logic [1:0] LK = 2'b01;
    localparam logic [1:0] L0 = 2'b00;
    localparam logic [1:0] L1 = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_dp, rx_dm, bit_stb;
    logic data_out, data_valid, pkt_active, sync_det, eop_det, rx_error;
`ifdef USB_RX_BUS_RESET_DET_EN
    logic bus_reset;
`endif

    usb_rx_nrzi_decoder #(.RESET_SE0_BITS(30)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_dp      (rx_dp),
        .rx_dm      (rx_dm),
        .bit_stb    (bit_stb),
        .data_out   (data_out),
        .data_valid (data_valid),
        .pkt_active (pkt_active),
        .sync_det   (sync_det),
        .eop_det    (eop_det),
        .rx_error   (rx_error)
`ifdef USB_RX_BUS_RESET_DET_EN
        ,
        .bus_reset  (bus_reset)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] line;
        logic       stb;
        logic [5:0] exp;  // {data_out, data_valid, pkt_active, sync_det, eop_det, rx_error}
    } vec_t;

    vec_t vecs[21];

    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_dv, n_sync, n_eop, n_err;
    logic [7:0] rx_byte;
    logic cur_j;

    function automatic logic [5:0] outs();
        return {data_out, data_valid, pkt_active, sync_det, eop_det, rx_error};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        n_dv = 0; n_sync = 0; n_eop = 0; n_err = 0; rx_byte = '0;
    endtask

    task automatic apply(input logic [1:0] ln, input logic s);
        @(negedge clk);
        rx_dp = ln[1]; rx_dm = ln[0]; bit_stb = s;
        @(posedge clk);
        #1;
        if (data_valid) begin
            n_dv++;
            rx_byte = {data_out, rx_byte[7:1]};
        end
        n_sync += int'(sync_det);
        n_eop  += int'(eop_det);
        n_err  += int'(rx_error);
        if (s && ln == LJ) cur_j = 1'b1;
        if (s && ln == LK) cur_j = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        apply((b ? cur_j : ~cur_j) ? LJ : LK, 1'b1);
    endtask

    task automatic send_sync();
        apply(LK, 1); apply(LJ, 1); apply(LK, 1); apply(LJ, 1);
        apply(LK, 1); apply(LJ, 1); apply(LK, 1); apply(LK, 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_eop();
        apply(L0, 1); apply(L0, 1); apply(LJ, 1);
    endtask

    initial begin
        vecs[0]  = '{LK, 1'b1, 6'b000000};
        vecs[1]  = '{LJ, 1'b1, 6'b000000};
        vecs[2]  = '{LK, 1'b1, 6'b000000};
        vecs[3]  = '{LJ, 1'b1, 6'b000000};
        vecs[4]  = '{LK, 1'b1, 6'b000000};
        vecs[5]  = '{LJ, 1'b1, 6'b000000};
        vecs[6]  = '{LK, 1'b1, 6'b000000};
        vecs[7]  = '{LK, 1'b1, 6'b001100};
        vecs[8]  = '{LK, 1'b1, 6'b111000};
        vecs[9]  = '{L1, 1'b0, 6'b101000};  // strobe low: SE1 must be ignored
        vecs[10] = '{LJ, 1'b1, 6'b011000};
        vecs[11] = '{LJ, 1'b1, 6'b111000};
        vecs[12] = '{LK, 1'b1, 6'b011000};
        vecs[13] = '{LJ, 1'b1, 6'b011000};
        vecs[14] = '{LJ, 1'b1, 6'b111000};
        vecs[15] = '{LK, 1'b1, 6'b011000};
        vecs[16] = '{LK, 1'b1, 6'b111000};
        vecs[17] = '{L0, 1'b1, 6'b101000};
        vecs[18] = '{L0, 1'b1, 6'b101000};
        vecs[19] = '{LJ, 1'b1, 6'b100010};
        vecs[20] = '{LJ, 1'b1, 6'b100000};

        rst_n = 1'b0; rx_dp = 1'b1; rx_dm = 1'b0; bit_stb = 1'b0; cur_j = 1'b1;
        clr();
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", 32'(outs()), 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // SYNC + 0xA5 + EOP, cycle by cycle
        for (int i = 0; i < 21; i++) begin
            apply(vecs[i].line, vecs[i].stb);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // 0xFF with a stuffed zero after the fifth data bit
        clr();
        send_sync();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        send_eop();
        chk("ff_sync", 32'(n_sync), 32'd1);
        chk("ff_dv_count", 32'(n_dv), 32'd8);
        chk("ff_byte", 32'(rx_byte), 32'hFF);
        chk("ff_eop", 32'(n_eop), 32'd1);
        chk("ff_err", 32'(n_err), 32'd0);

        // Seven consecutive ones (SYNC's last bit plus six data ones) with no stuff
        clr();
        send_sync();
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        chk("stuff_err", 32'(n_err), 32'd1);
        chk("stuff_pkt", 32'(pkt_active), 32'd0);
        chk("stuff_dv", 32'(n_dv), 32'd5);
        apply(LJ, 1); apply(LJ, 1); apply(LJ, 1);
        chk("stuff_no_more_dv", 32'(n_dv), 32'd5);
        clr();
        send_sync();
        send_byte(8'h3C);
        send_eop();
        chk("resync_sync", 32'(n_sync), 32'd1);
        chk("resync_byte", 32'(rx_byte), 32'h3C);
        chk("resync_eop", 32'(n_eop), 32'd1);

        // KJKJKJKJ is not a SYNC
        clr();
        for (int i = 0; i < 4; i++) begin apply(LK, 1); apply(LJ, 1); end
        chk("badsync_sync", 32'(n_sync), 32'd0);
        chk("badsync_dv", 32'(n_dv), 32'd0);
        chk("badsync_pkt", 32'(pkt_active), 32'd0);
        send_sync();
        chk("badsync_then_sync", 32'(n_sync), 32'd1);
        send_byte(8'h5A);
        chk("badsync_byte", 32'(rx_byte), 32'h5A);

        // EOP with too many SE0 bit-times
        clr();
        for (int i = 0; i < 4; i++) apply(L0, 1);
        apply(LJ, 1);
        chk("long_eop_err", 32'(n_err), 32'd1);
        chk("long_eop_eop", 32'(n_eop), 32'd0);
        chk("long_eop_pkt", 32'(pkt_active), 32'd0);

        // SE1 inside a packet
        clr();
        send_sync();
        send_bit(1'b0);
        apply(L1, 1);
        chk("se1_err", 32'(n_err), 32'd1);
        chk("se1_pkt", 32'(pkt_active), 32'd0);
        apply(LJ, 1); apply(LJ, 1);

`ifdef USB_RX_BUS_RESET_DET_EN
        for (int i = 0; i < 29; i++) apply(L0, 1);
        chk("busrst_before", 32'(bus_reset), 32'd0);
        apply(L0, 1);
        chk("busrst_after30", 32'(bus_reset), 32'd1);
        apply(L0, 0);
        chk("busrst_hold", 32'(bus_reset), 32'd1);
        apply(LJ, 1);
        chk("busrst_clear", 32'(bus_reset), 32'd0);
`endif

        // Asynchronous reset mid-packet after three data bits
        clr();
        send_sync();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        @(negedge clk);
        bit_stb = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("midpkt_reset", 32'(outs()), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        cur_j = 1'b1;
        clr();
        send_sync();
        send_byte(8'hA5);
        send_eop();
        chk("post_reset_sync", 32'(n_sync), 32'd1);
        chk("post_reset_byte", 32'(rx_byte), 32'hA5);
        chk("post_reset_dv", 32'(n_dv), 32'd8);
        chk("post_reset_eop", 32'(n_eop), 32'd1);
        chk("post_reset_err", 32'(n_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
